// File: rtl/lab7_soc_out_pulse.sv
// lab7_soc_out_pulse
// Memory-mapped 8-bit output port with bit set/clear registers and a
// self-clearing pulse generator. A PULSE write raises the selected bits
// and a 16-bit down-counter lowers them again after max(len,1) cycles.
// Retriggering while a pulse runs merges the new bits into the running
// group, and the whole group clears together at the reloaded expiry.

module lab7_soc_out_pulse (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic [7:0]  out_port
);

   localparam logic [2:0] ADDR_DATA      = 3'd0;
   localparam logic [2:0] ADDR_PULSE_LEN = 3'd2;
   localparam logic [2:0] ADDR_OUTSET    = 3'd4;
   localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;
   localparam logic [2:0] ADDR_PULSE     = 3'd6;

   logic [7:0]  data;
   logic [7:0]  mask;
   logic [15:0] len;
   logic [15:0] cnt;
   logic        busy;

   logic [7:0]  data_nxt;
   logic [7:0]  mask_nxt;
   logic [15:0] len_nxt;
   logic [15:0] cnt_nxt;
   logic        busy_nxt;
   logic [31:0] read_nxt;

   logic        wr_en;
   logic        expire;
   logic [15:0] load_len;

   // A zero length still produces a one-cycle pulse.
   assign wr_en    = chipselect & ~write_n;
   assign expire   = busy && (cnt == 16'd1);
   assign load_len = (len == 16'd0) ? 16'd1 : len;
   assign out_port = data;

   // Next register state: expiry clear first, then any write on top of it.
   always_comb begin
      data_nxt = data;
      mask_nxt = mask;
      len_nxt  = len;
      cnt_nxt  = cnt;
      busy_nxt = busy;

      if (expire) begin
         data_nxt = data & ~mask;
         mask_nxt = 8'h00;
         busy_nxt = 1'b0;
         cnt_nxt  = 16'd0;
      end else if (busy && (cnt != 16'd0)) begin
         cnt_nxt = cnt - 16'd1;
      end

      if (wr_en) begin
         case (address)
            ADDR_DATA:      data_nxt = writedata[7:0];
            ADDR_PULSE_LEN: len_nxt  = writedata[15:0];
            ADDR_OUTSET:    data_nxt = data_nxt | writedata[7:0];
            ADDR_OUTCLEAR:  data_nxt = data_nxt & ~writedata[7:0];
            ADDR_PULSE: begin
               if (writedata[7:0] != 8'h00) begin
                  data_nxt = data_nxt | writedata[7:0];
                  mask_nxt = mask_nxt | writedata[7:0];
                  cnt_nxt  = load_len;
                  busy_nxt = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Read mux, sampled every cycle regardless of chipselect.
   always_comb begin
      read_nxt = 32'h0000_0000;
      case (address)
         ADDR_DATA:      read_nxt = {24'h00_0000, data};
         ADDR_PULSE_LEN: read_nxt = {16'h0000, len};
         ADDR_PULSE:     read_nxt = {15'h0000, busy, 8'h00, mask};
         default:        read_nxt = 32'h0000_0000;
      endcase
   end

   // State and read-data registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data     <= 8'h00;
         mask     <= 8'h00;
         len      <= 16'd1;
         cnt      <= 16'd0;
         busy     <= 1'b0;
         readdata <= 32'h0000_0000;
      end else begin
         data     <= data_nxt;
         mask     <= mask_nxt;
         len      <= len_nxt;
         cnt      <= cnt_nxt;
         busy     <= busy_nxt;
         readdata <= read_nxt;
      end
   end

endmodule

// File: doc/lab7_soc_out_pulse.md
LAB7_SOC_OUT_PULSE -- requirements
Module: lab7_soc_out_pulse

Interface
REQ-001 SHALL have port clk, input, 1: system clock; all state changes on rising edge.
REQ-002 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port address, input, 3: register select (word offset).
REQ-004 SHALL have port chipselect, input, 1: slave select, active-high.
REQ-005 SHALL have port write_n, input, 1: write strobe, active-low; a write occurs only when chipselect=1 and write_n=0.
REQ-006 SHALL have port writedata, input, 32: write data.
REQ-007 SHALL have port readdata, output, 32: registered read data.
REQ-008 SHALL have port out_port, output, 8: output pins, driven directly from the DATA register.

Function
REQ-009 SHALL implement this register map: 0 DATA R/W [7:0]; 2 PULSE_LEN R/W [15:0]; 4 OUTSET W; 5 OUTCLEAR W; 6 PULSE R/W; offsets 1, 3 and 7 are reserved, read 0, and ignore writes.
REQ-010 SHALL update readdata every clock, independent of chipselect, with the value selected by address: one-cycle read latency, unused bits 0.
REQ-011 SHALL return on reads: DATA at offset 0 -> {24'b0, data}; PULSE_LEN at offset 2 -> {16'b0, len}; offsets 4 and 5 -> 0; PULSE at offset 6 -> {15'b0, busy, 8'b0, mask}.
REQ-012 SHALL handle writes as follows: offset 0 -> data <= writedata[7:0]; offset 2 -> len <= writedata[15:0]; other writedata bits ignored.
REQ-013 SHALL, on an OUTSET write, set data <= data | writedata[7:0].
REQ-014 SHALL, on an OUTCLEAR write, set data <= data & ~writedata[7:0].
REQ-015 SHALL, on a PULSE write with writedata[7:0] != 0, set data bits in writedata[7:0], OR them into mask, load cnt with max(len,1), and set busy=1.
REQ-016 SHALL treat a PULSE write with writedata[7:0]=0 as a no-op.
REQ-017 SHALL, while busy=1, decrement cnt by 1 per clock.
REQ-018 SHALL expire a pulse in the cycle where cnt=1 and busy=1: at the next edge data <= data & ~mask, mask <= 0, busy <= 0, cnt <= 0.
REQ-019 SHALL hold each pulsed bit high on out_port for exactly max(len,1) cycles, from the edge after the PULSE write.
REQ-020 SHALL retrigger on a PULSE write while busy: mask ORs in the new bits and cnt reloads to max(len,1), so all masked bits then clear together.
REQ-021 SHALL, when a write coincides with an expiry cycle, apply the expiry clear first and the write on top of the result.
REQ-022 SHALL, for a PULSE write in an expiry cycle, retire the old mask and make the new mask = writedata[7:0] only, with busy staying 1.
REQ-023 SHALL allow DATA, OUTSET and OUTCLEAR writes during a pulse to alter data freely; expiry still clears the mask bits.
REQ-024 SHALL make a PULSE_LEN write during a pulse affect only subsequent loads, not the running cnt.
REQ-025 SHALL use a 16-bit cnt with no wrap-around: it never decrements below 0 and never decrements while busy=0.

Reset
REQ-026 SHALL, on reset_n=0 at any time including mid-pulse, immediately force data=0, out_port=0, mask=0, busy=0, cnt=0, len=16'd1, and readdata=0.
REQ-027 SHALL, after reset deassertion, resume normal operation on the first rising clk edge.

Verification
REQ-028 SHALL cover a DATA write/read: write 0x5A to offset 0 -> out_port=0x5A next cycle; read offset 0 -> readdata=0x0000005A one cycle after address is applied.
REQ-029 SHALL cover set/clear: with DATA=0x0F, OUTSET 0xF0 -> 0xFF; then OUTCLEAR 0x81 -> 0x7E.
REQ-030 SHALL cover a single pulse: len=5, PULSE 0x03 -> out_port[1:0]=11 for exactly 5 cycles then 00, busy read 1 during the pulse and 0 after, with other bits unchanged.
REQ-031 SHALL cover a retrigger: len=10, PULSE 0x01, then PULSE 0x02 after 4 cycles -> bits 0 and 1 both clear 10 cycles after the second write.
REQ-032 SHALL cover edge cases: len=0 with PULSE 0x80 -> bit 7 high for 1 cycle; OUTSET 0x80 in the expiry cycle -> bit 7 stays 1.
REQ-033 SHALL cover reset mid-pulse: assert reset_n=0 during an active pulse -> out_port=0, busy=0 and len=1 asynchronously, with no spurious expiry after release.
